// File: rtl/disp_bcd_scan_if.sv
// disp_bcd_scan_if: load/convert handshake and scanned digit bus of the BCD display feeder
interface disp_bcd_scan_if;
  logic       load;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [3:0] digit;
  logic [2:0] an;
  modport master (output load, data_in, input busy, done, digit, an);
  modport slave  (input load, data_in, output busy, done, digit, an);
endinterface

// File: rtl/disp_bcd_scan.sv
// disp_bcd_scan: 8-bit binary to 3-digit BCD (double dabble) with multiplexed common-anode scan
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module disp_bcd_scan #(
  parameter int SCAN_DIV = 50000
) (
  input logic            clk,
  input logic            rst_n,
  disp_bcd_scan_if.slave bus
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [0:0] IDLE = 1'b0, CONV = 1'b1;
  logic [0:0] state;
  logic [19:0] sh, nxt;
  logic [11:0] adj;
  logic [2:0] it;
  logic [3:0] ones, tens, hund, ones_n, tens_n, hund_n;
  logic [CW-1:0] scnt;
  logic [1:0] idx, idx_n;
  logic [2:0] an_r, an_n;
  logic done_r, commit, wrap;
  always_comb begin
    adj[3:0]   = sh[11:8]  >= 4'd5 ? sh[11:8]  + 4'd3 : sh[11:8];
    adj[7:4]   = sh[15:12] >= 4'd5 ? sh[15:12] + 4'd3 : sh[15:12];
    adj[11:8]  = sh[19:16] >= 4'd5 ? sh[19:16] + 4'd3 : sh[19:16];
    nxt = {adj, sh[7:0]} << 1;
    commit = state == CONV && it == 3'd7;
    {hund_n, tens_n, ones_n} = commit ? nxt[19:8] : {hund, tens, ones};
    wrap = scnt == CW'(SCAN_DIV - 1);
    idx_n = wrap ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
    an_n = idx_n == 2'd0 ? 3'b110 : idx_n == 2'd1 ? 3'b101 : 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
    an_n = (idx_n == 2'd2 && hund_n == 4'd0) || (idx_n == 2'd1 && hund_n == 4'd0 && tens_n == 4'd0) ? 3'b111 : an_n;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      it <= '0;
      {hund, tens, ones} <= '0;
      done_r <= 1'b0;
      scnt <= '0;
      idx <= '0;
      an_r <= 3'b110;
    end else begin
      done_r <= commit;
      {hund, tens, ones} <= {hund_n, tens_n, ones_n};
      scnt <= wrap ? '0 : scnt + CW'(1);
      idx <= idx_n;
      an_r <= an_n;
      if (state == IDLE) begin
        if (bus.load) begin
          sh <= {12'd0, bus.data_in};
          it <= '0;
          state <= CONV;
        end
      end else begin
        sh <= nxt;
        it <= it + 3'd1;
        if (commit) state <= IDLE;
      end
    end
  end
  assign bus.busy  = state == CONV;
  assign bus.done  = done_r;
  assign bus.an    = an_r;
  assign bus.digit = idx == 2'd0 ? ones : idx == 2'd1 ? tens : hund;
endmodule

// File: tb/tb_disp_bcd_scan.sv
// tb_disp_bcd_scan: directed stimulus, arithmetic reference model checked every cycle
module tb_disp_bcd_scan;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0, errors = 0;
  disp_bcd_scan_if bus();
  disp_bcd_scan #(.SCAN_DIV(SD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  bit armed = 0, m_busy = 0, m_done = 0;
  int m_left = 0, m_val = 0, m_h = 0, m_t = 0, m_o = 0, m_k = 0;
  // Reference: value converted by division, scan slot derived from edges since reset
  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1; m_busy = 0; m_done = 0; m_left = 0;
      m_h = 0; m_t = 0; m_o = 0; m_k = 0;
    end else begin
      m_k++;
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
          m_h = m_val / 100; m_t = (m_val / 10) % 10; m_o = m_val % 10;
        end
      end else if (bus.load) begin
        m_busy = 1; m_left = 8; m_val = int'(bus.data_in);
      end
    end
  end

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_an(int i);
    logic [2:0] a;
    a = i == 0 ? 3'b110 : i == 1 ? 3'b101 : 3'b011;
`ifdef LEADING_ZERO_BLANK_EN
    if ((i == 2 && m_h == 0) || (i == 1 && m_h == 0 && m_t == 0)) a = 3'b111;
`endif
    return a;
  endfunction

  always @(negedge clk) begin
    int i;
    if (armed) begin
      i = (m_k / SD) % 3;
      chk("busy", 8'(bus.busy), 8'(m_busy));
      chk("done", 8'(bus.done), 8'(m_done));
      chk("an", 8'(bus.an), 8'(exp_an(i)));
      chk("digit", 8'(bus.digit), 8'(i == 0 ? m_o : i == 1 ? m_t : m_h));
    end
  end

  task automatic check_scan(int h, int t, int o);
    repeat (3 * SD) begin
      @(negedge clk);
      case (bus.an)
        3'b110: chk("lit_ones", 8'(bus.digit), 8'(o));
        3'b101: chk("lit_tens", 8'(bus.digit), 8'(t));
        3'b011: chk("lit_hund", 8'(bus.digit), 8'(h));
        3'b111: ;
        default: chk("lit_an_onehot", 8'(bus.an), 8'h0);
      endcase
    end
  endtask

  task automatic do_load(logic [7:0] v, int h, int t, int o);
    int n;
    @(negedge clk); bus.load = 1'b1; bus.data_in = v;
    @(negedge clk); bus.load = 1'b0;
    n = 1;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", 8'(n - 1), 8'd8);
    check_scan(h, t, o);
  endtask

  initial begin
    bus.load = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_an", 8'(bus.an), 8'(3'b110));
    chk("rst_digit", 8'(bus.digit), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    repeat (3) check_scan(0, 0, 0);
    do_load(8'd255, 2, 5, 5);
    // 42 with ignored loads at N+3 and N+8, load held through N+9 converts 200
    @(negedge clk); bus.load = 1'b1; bus.data_in = 8'd42;
    @(negedge clk); bus.load = 1'b0; bus.data_in = 8'd200;
    repeat (2) @(negedge clk);
    bus.load = 1'b1;
    @(negedge clk); bus.load = 1'b0;
    repeat (4) @(negedge clk);
    bus.load = 1'b1;
    @(negedge clk);
    chk("commit42_done", 8'(bus.done), 8'd1);
    chk("commit42_busy", 8'(bus.busy), 8'd0);
    @(negedge clk); bus.load = 1'b0;
    chk("retrigger_busy", 8'(bus.busy), 8'd1);
    repeat (8) @(negedge clk);
    chk("commit200_done", 8'(bus.done), 8'd1);
    check_scan(2, 0, 0);
    do_load(8'd0, 0, 0, 0);
    do_load(8'd9, 0, 0, 9);
    do_load(8'd100, 1, 0, 0);
    do_load(8'd128, 1, 2, 8);
    // 77 aborted by reset at N+4
    @(negedge clk); bus.load = 1'b1; bus.data_in = 8'd77;
    @(negedge clk); bus.load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("abort_busy", 8'(bus.busy), 8'd0);
    chk("abort_an", 8'(bus.an), 8'(3'b110));
    chk("abort_digit", 8'(bus.digit), 8'd0);
    check_scan(0, 0, 0);
`ifdef LEADING_ZERO_BLANK_EN
    do_load(8'd7, 0, 0, 7);
    do_load(8'd105, 1, 0, 5);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
